// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg: shared 7-segment pattern constants, digit codes and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}; shared with the encoder
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hA;
  localparam logic [3:0] DIGIT_ERR   = 4'hF;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_frame_decoder_if: segment beat input and frame output handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seg_frame_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 8
);

  logic [6:0]              seg_in;
  logic                    seg_valid;
  logic                    seg_ready;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic                    frame_valid;
  logic                    frame_ack;
  logic                    pattern_error;
  logic [ERR_CNT_W-1:0]    err_count;

  modport master (
    output seg_in, seg_valid, frame_ack,
    input  seg_ready, digits_out, frame_valid, pattern_error, err_count
  );

  modport slave (
    input  seg_in, seg_valid, frame_ack,
    output seg_ready, digits_out, frame_valid, pattern_error, err_count
  );

endinterface

`default_nettype wire

// File: rtl/seg_pattern_lut.sv
// ---------------------------------------------------------------------------
// seg_pattern_lut: active-low 7-segment pattern to 4-bit digit code
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = DIGIT_ERR;
    valid = 1'b1;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default: begin
        digit = DIGIT_ERR;
        valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_frame_decoder.sv
// ---------------------------------------------------------------------------
// seg_frame_decoder: collects NUM_DIGITS decoded segment beats into a frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_frame_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  seg_frame_decoder_if.slave  bus
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     count;
  logic [DW-1:0]        shift_reg;
  logic [DW-1:0]        shift_nxt;
  logic [DW-1:0]        digits;
  logic                 frame_valid;
  logic                 pattern_error;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 seg_ready;
  logic                 accept;
  logic                 last_beat;
  logic [3:0]           dec_digit;
  logic                 dec_valid;

  seg_pattern_lut u_lut (
    .pattern (bus.seg_in),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  always_comb begin
    state_nxt = state;
    seg_ready = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state)
      COLLECT: begin
        seg_ready = 1'b1;
        accept    = bus.seg_valid & ~clear;
        last_beat = accept & (count == LAST);
        if (last_beat) state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.frame_ack) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= COLLECT;
    else if (clear) state <= COLLECT;
    else            state <= state_nxt;
  end

  // Newest digit enters the LS nibble, so digit 0 ends up in the MS nibble
  assign shift_nxt = (shift_reg << 4) | DW'(dec_digit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      shift_reg     <= '0;
      digits        <= '0;
      frame_valid   <= 1'b0;
      pattern_error <= 1'b0;
      err_count     <= '0;
    end else if (clear) begin
      count         <= '0;
      shift_reg     <= '0;
      digits        <= '0;
      frame_valid   <= 1'b0;
      pattern_error <= 1'b0;
      err_count     <= '0;
    end else if (accept) begin
      if (last_beat) begin
        digits      <= shift_nxt;
        frame_valid <= 1'b1;
        count       <= '0;
        shift_reg   <= '0;
      end else begin
        shift_reg   <= shift_nxt;
        count       <= count + 1'b1;
      end
      // First beat of a frame restarts the sticky error flag
      if (count == '0) pattern_error <= ~dec_valid;
      else             pattern_error <= pattern_error | ~dec_valid;
      if (!dec_valid && !(&err_count)) err_count <= err_count + 1'b1;
    end else if (state == HOLD && bus.frame_ack) begin
      frame_valid <= 1'b0;
    end
  end

  assign bus.seg_ready     = seg_ready;
  assign bus.digits_out    = digits;
  assign bus.frame_valid   = frame_valid;
  assign bus.pattern_error = pattern_error;
  assign bus.err_count     = err_count;

endmodule

`default_nettype wire

// File: tb/tb_seg_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_frame_decoder: directed scoreboard bench for seg_frame_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_frame_decoder;

  typedef struct {
    logic [15:0] d;
    logic        pe;
    logic [7:0]  ec;
  } exp_t;

  logic clk;
  logic reset_n;
  logic clear;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [15:0] m_shift;
  int          m_cnt;
  logic        m_pe;
  logic [7:0]  m_ec;

  seg_frame_decoder_if #(.NUM_DIGITS(4), .ERR_CNT_W(8)) bus ();

  seg_frame_decoder #(.NUM_DIGITS(4), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference table: {invalid, digit}
  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    case (p)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0011000: return 5'h09;
      7'b1111111: return 5'h0A;
      default:    return 5'h1F;
    endcase
  endfunction

  task automatic model_reset();
    m_shift = '0;
    m_cnt   = 0;
    m_pe    = 1'b0;
    m_ec    = '0;
  endtask

  task automatic send_beat(input logic [6:0] p);
    logic [4:0] r;
    int         n;
    exp_t       e;
    bus.seg_in    = p;
    bus.seg_valid = 1'b1;
    n = 0;
    while (bus.seg_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("beat_ready_timeout", {63'd0, bus.seg_ready}, 64'd1);
    @(posedge clk); #1;
    bus.seg_valid = 1'b0;
    r = ref_dec(p);
    m_shift = {m_shift[11:0], r[3:0]};
    if (m_cnt == 0) m_pe = r[4];
    else            m_pe = m_pe | r[4];
    if (r[4] && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    m_cnt++;
    if (m_cnt == 4) begin
      e.d = m_shift; e.pe = m_pe; e.ec = m_ec;
      sb.push_back(e);
      m_cnt   = 0;
      m_shift = '0;
    end
  endtask

  task automatic check_frame(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.frame_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, {63'd0, bus.frame_valid}, 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_digits"}, {48'd0, bus.digits_out}, {48'd0, e.d});
      check({tag, "_perr"}, {63'd0, bus.pattern_error}, {63'd0, e.pe});
      check({tag, "_errcnt"}, {56'd0, bus.err_count}, {56'd0, e.ec});
      check({tag, "_ready"}, {63'd0, bus.seg_ready}, 64'd0);
    end
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    bus.seg_valid = 1'b0;
    check("ack_drops_valid", {63'd0, bus.frame_valid}, 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    bus.seg_in    = 7'b1111111;
    bus.seg_valid = 1'b0;
    bus.frame_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_digits", {48'd0, bus.digits_out}, 64'd0);
    check("rst_fvalid", {63'd0, bus.frame_valid}, 64'd0);
    check("rst_perr", {63'd0, bus.pattern_error}, 64'd0);
    check("rst_errcnt", {56'd0, bus.err_count}, 64'd0);
    check("rst_ready", {63'd0, bus.seg_ready}, 64'd1);

    // Frame 1234, zero-latency completion
    send_beat(7'b1111001);
    send_beat(7'b0100100);
    send_beat(7'b0110000);
    check("f1_not_early", {63'd0, bus.frame_valid}, 64'd0);
    send_beat(7'b0011001);
    check("f1_latency", {63'd0, bus.frame_valid}, 64'd1);
    check_frame("f1");

    // Hold the frame with a pending beat
    bus.seg_in    = 7'b0000000;
    bus.seg_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("hold_digits", {48'd0, bus.digits_out}, 64'h1234);
    check("hold_fvalid", {63'd0, bus.frame_valid}, 64'd1);
    check("hold_ready", {63'd0, bus.seg_ready}, 64'd0);
    ack_frame();
    repeat (4) send_beat(7'b0000000);
    check_frame("f8888");
    ack_frame();

    // Ack during COLLECT is ignored
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    check("collect_ack_ready", {63'd0, bus.seg_ready}, 64'd1);
    check("collect_ack_fvalid", {63'd0, bus.frame_valid}, 64'd0);

    // Blank plus one invalid pattern
    send_beat(7'b1000000);
    send_beat(7'b1111111);
    send_beat(7'b0101010);
    send_beat(7'b0011000);
    check_frame("f0af9");
    ack_frame();

    // First valid beat of next frame clears the sticky error; then clear
    send_beat(7'b0010010);
    check("perr_cleared", {63'd0, bus.pattern_error}, 64'd0);
    send_beat(7'b0010010);
    clear         = 1'b1;
    bus.seg_in    = 7'b0010010;
    bus.seg_valid = 1'b1;
    @(posedge clk); #1;
    clear         = 1'b0;
    bus.seg_valid = 1'b0;
    model_reset();
    check("clr_digits", {48'd0, bus.digits_out}, 64'd0);
    check("clr_errcnt", {56'd0, bus.err_count}, 64'd0);
    check("clr_perr", {63'd0, bus.pattern_error}, 64'd0);
    check("clr_fvalid", {63'd0, bus.frame_valid}, 64'd0);
    repeat (4) send_beat(7'b0010010);
    check_frame("f5555");
    ack_frame();

    // Saturation of the invalid-pattern counter
    for (int f = 0; f < 75; f++) begin
      repeat (4) send_beat(7'b0101010);
      check_frame("sat");
      ack_frame();
    end
    check("sat_final", {56'd0, bus.err_count}, 64'd255);

    // Asynchronous reset mid-frame
    send_beat(7'b0011000);
    send_beat(7'b1111000);
    #3 reset_n = 1'b0;
    #1;
    check("arst_digits", {48'd0, bus.digits_out}, 64'd0);
    check("arst_errcnt", {56'd0, bus.err_count}, 64'd0);
    check("arst_perr", {63'd0, bus.pattern_error}, 64'd0);
    check("arst_fvalid", {63'd0, bus.frame_valid}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    send_beat(7'b0011000);
    send_beat(7'b1111000);
    check("arst_no_early", {63'd0, bus.frame_valid}, 64'd0);
    send_beat(7'b0000010);
    send_beat(7'b0010010);
    check_frame("f9765");
    ack_frame();

    check("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
